ehgu_clkdiv_sw: RTL and testbench
=================================

EHGU_CLKDIV_SW -- requirements
Module: ehgu_clkdiv_sw

Interface
REQ-001 The block SHALL have the parameter CNT_W, default 8, meaning the width of the divide ratio.
REQ-002 The block SHALL have the parameter RST_RATIO, default 4, meaning the divide ratio after reset (legal range 2..2^CNT_W-1).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; there SHALL be only one clock.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have the port en, input, 1 bit: run request; high means clkdiv toggles.
REQ-006 The block SHALL have the port req_valid, input, 1 bit: ratio change request.
REQ-007 The block SHALL have the port req_ratio, input, CNT_W bits: the requested ratio.
REQ-008 The block SHALL have the port req_ready, output, 1 bit: the block can accept a request.
REQ-009 The block SHALL have the port clkdiv, output, 1 bit: divided clock, driven directly from a flop.
REQ-010 The block SHALL have the port tick, output, 1 bit: one-cycle pulse coincident with the first high cycle of each clkdiv period.
REQ-011 The block SHALL have the port cur_ratio, output, CNT_W bits: the ratio currently in force.
REQ-012 The block SHALL have the port running, output, 1 bit: high while in RUN or DRAIN.
REQ-013 The block SHALL have the port err, output, 1 bit: one-cycle pulse when an illegal ratio is accepted.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DRAIN, with a period counter cnt running 0..cur_ratio-1.
REQ-015 For R = cur_ratio and H = floor(R/2), clkdiv SHALL be high for cnt in 0..H-1 and low for cnt in H..R-1, giving a period of exactly R clk cycles.
REQ-016 In IDLE, clkdiv SHALL be 0 and cnt SHALL be 0.
REQ-017 IDLE SHALL go to RUN when en=1 is sampled, with cnt=0, clkdiv=1 and tick=1 in the next cycle (1-cycle latency).
REQ-018 In RUN, cnt SHALL increment and wrap from R-1 to 0; each wrap SHALL start a new period with tick=1.
REQ-019 RUN SHALL go to DRAIN when en=0 is sampled at any cnt other than R-1; at cnt=R-1 it SHALL go directly to IDLE.
REQ-020 DRAIN SHALL complete the current period and go to IDLE at cnt=R-1, so that no truncated high or low phase ever occurs.
REQ-021 DRAIN SHALL return to RUN with no phase disturbance if en=1 is sampled before the period ends.
REQ-022 A request SHALL be accepted when req_valid and req_ready are both 1.
REQ-023 In IDLE, an accepted legal ratio SHALL load cur_ratio on the next edge, and req_ready SHALL stay 1.
REQ-024 In RUN/DRAIN, an accepted legal ratio SHALL be held in a pending register, and req_ready SHALL be 0 until that ratio is applied.
REQ-025 A pending ratio SHALL load cur_ratio at the next wrap edge (cnt R-1 to 0), and req_ready SHALL return to 1 in the following cycle.
REQ-026 A request accepted on the same edge as a wrap SHALL apply at the next wrap, not the current one.
REQ-027 A pending ratio SHALL survive a transition to IDLE and SHALL then be applied on the IDLE entry edge.
REQ-028 req_ratio values 0 and 1 SHALL be illegal: when accepted they SHALL produce err=1 for one cycle and be discarded; cur_ratio and the pending state SHALL be unchanged.
REQ-029 Odd ratios SHALL give a low phase one cycle longer than the high phase (e.g. R=5: 2 high, 3 low).
REQ-030 cur_ratio SHALL change only at period boundaries or in IDLE; an output period SHALL never mix two ratios.

Reset
REQ-031 When rst=1 is sampled: state=IDLE, cnt=0, clkdiv=0, tick=0, err=0, running=0, req_ready=1, cur_ratio=RST_RATIO, and the pending register SHALL be cleared.
REQ-032 Reset mid-period SHALL force clkdiv low on the next edge, overriding DRAIN completion.
REQ-033 Reset SHALL take priority over en and req_valid sampled on the same edge.

Structure
REQ-034 Package ehgu_clkdiv_pkg SHALL hold the FSM state enum, the minimum legal ratio constant (2) and the CNT_W default.
REQ-035 The block SHALL be a single module without sub-modules; a separate counter module is not warranted.
REQ-036 clkdiv, tick and err SHALL be flop outputs with no combinational path to any output.

Verification
REQ-037 Reset, en=1, ratio 4: clkdiv SHALL be 1,1,0,0 repeating, tick every 4th cycle, first high cycle 1 cycle after en is sampled.
REQ-038 Running at R=4, request R=7 accepted at cnt=1: the current period SHALL finish as 4 cycles, followed by 3-high/4-low periods; req_ready SHALL be low for 3 cycles.
REQ-039 Request R=1 while running: err SHALL pulse for 1 cycle and the period SHALL stay unchanged.
REQ-040 R=6, en dropped at cnt=1: the period SHALL complete (6 cycles total), then IDLE with clkdiv=0; en re-raised at cnt=3 SHALL continue without any gap.
REQ-041 rst asserted at cnt=1 with R=6: clkdiv=0 on the next cycle, and cur_ratio SHALL return to 4.
REQ-042 A request accepted exactly on the wrap edge SHALL apply one period later; checked for both R=2 and R=255.

Source files
------------

// File: rtl/ehgu_clkdiv_pkg.sv
// Shared types and constants for the software-programmable clock divider.
// The divider FSM and the ratio limits live here so the top and any wrapper agree.
package ehgu_clkdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int MIN_RATIO = 2;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/ehgu_clkdiv_sw.sv
// Programmable integer clock divider: clkdiv is high for floor(R/2) of every R clk cycles.
// Ratio changes are buffered and only take effect on period boundaries or while idle.
module ehgu_clkdiv_sw
   import ehgu_clkdiv_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int RST_RATIO = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req_valid,
   input  logic [CNT_W-1:0] req_ratio,
   output logic             req_ready,
   output logic             clkdiv,
   output logic             tick,
   output logic [CNT_W-1:0] cur_ratio,
   output logic             running,
   output logic             err
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_ratio_q, cur_ratio_d;
   logic [CNT_W-1:0] pend_ratio_q, pend_ratio_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clkdiv_q, clkdiv_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;

   logic             req_acc;
   logic             req_legal;
   logic             wrap;
   logic             run_d;
   logic [CNT_W-1:0] last_cnt;

   // A pending ratio blocks further requests until it has been applied.
   assign req_ready = ~pend_vld_q;
   assign req_acc   = req_valid & req_ready;
   assign req_legal = (req_ratio >= CNT_W'(MIN_RATIO));
   assign last_cnt  = cur_ratio_q - CNT_W'(1);
   assign wrap      = (cnt_q == last_cnt);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_ratio_d  = cur_ratio_q;
      pend_ratio_d = pend_ratio_q;
      pend_vld_d   = pend_vld_q;
      err_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // A request that landed on the IDLE entry edge is still pending here.
            if (pend_vld_q) begin
               cur_ratio_d = pend_ratio_q;
               pend_vld_d  = 1'b0;
            end else if (req_acc && req_legal) begin
               cur_ratio_d = req_ratio;
            end
            if (en) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN, ST_DRAIN: begin
            if (wrap) begin
               cnt_d   = '0;
               state_d = en ? ST_RUN : ST_IDLE;
               if (pend_vld_q) begin
                  cur_ratio_d = pend_ratio_q;
                  pend_vld_d  = 1'b0;
               end
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = en ? ST_RUN : ST_DRAIN;
            end
            // Only reachable when nothing is pending, so this never clobbers the load above.
            if (req_acc && req_legal) begin
               pend_vld_d   = 1'b1;
               pend_ratio_d = req_ratio;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (req_acc && !req_legal) begin
         err_d = 1'b1;
      end

      // Outputs are registered from next-state values so they line up with cnt_q.
      run_d    = (state_d != ST_IDLE);
      clkdiv_d = run_d && (cnt_d < (cur_ratio_d >> 1));
      tick_d   = run_d && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_ratio_q  <= CNT_W'(RST_RATIO);
         pend_ratio_q <= '0;
         pend_vld_q   <= 1'b0;
         clkdiv_q     <= 1'b0;
         tick_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_ratio_q  <= cur_ratio_d;
         pend_ratio_q <= pend_ratio_d;
         pend_vld_q   <= pend_vld_d;
         clkdiv_q     <= clkdiv_d;
         tick_q       <= tick_d;
         err_q        <= err_d;
      end
   end

   assign clkdiv    = clkdiv_q;
   assign tick      = tick_q;
   assign err       = err_q;
   assign cur_ratio = cur_ratio_q;
   assign running   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ehgu_clkdiv_sw.sv
// Directed bench for ehgu_clkdiv_sw: waveform shape, ratio handoff, drain and reset behaviour.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ehgu_clkdiv_sw;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       req_valid;
   logic [7:0] req_ratio;
   logic       req_ready;
   logic       clkdiv;
   logic       tick;
   logic [7:0] cur_ratio;
   logic       running;
   logic       err;

   int n_pass  = 0;
   int n_total = 0;

   ehgu_clkdiv_sw #(.CNT_W(8), .RST_RATIO(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_ratio (req_ratio),
      .req_ready (req_ready),
      .clkdiv    (clkdiv),
      .tick      (tick),
      .cur_ratio (cur_ratio),
      .running   (running),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; req_valid = 1'b0; req_ratio = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (clkdiv !== 1'b0) $display("FAIL rst_clkdiv got %b exp 0", clkdiv); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL rst_tick got %b exp 0", tick); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
      n_total++; if (running !== 1'b0) $display("FAIL rst_running got %b exp 0", running); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
      n_total++; if (cur_ratio !== 8'd4) $display("FAIL rst_ratio got %0d exp 4", cur_ratio); else n_pass++;
   endtask

   // Ratio 4: 1,1,0,0 with tick on the first high cycle, one cycle after en is sampled.
   task automatic test_ratio4();
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_total++; if (clkdiv !== ((i % 4) < 2)) $display("FAIL r4_clk i=%0d got %b exp %b", i, clkdiv, (i % 4) < 2); else n_pass++;
         n_total++; if (tick !== ((i % 4) == 0)) $display("FAIL r4_tick i=%0d got %b exp %b", i, tick, (i % 4) == 0); else n_pass++;
         n_total++; if (running !== 1'b1) $display("FAIL r4_running i=%0d got %b exp 1", i, running); else n_pass++;
      end
   endtask

   // Request 7 accepted on the edge into cnt=1; the 4-cycle period finishes, then 3-high/4-low.
   task automatic test_ratio_change();
      @(negedge clk);
      n_total++; if (tick !== 1'b1) $display("FAIL chg_tick0 got %b exp 1", tick); else n_pass++;
      req_valid = 1'b1; req_ratio = 8'd7;
      for (int j = 1; j < 4; j++) begin
         @(negedge clk);
         req_valid = 1'b0;
         n_total++; if (req_ready !== 1'b0) $display("FAIL chg_ready_low j=%0d got %b exp 0", j, req_ready); else n_pass++;
         n_total++; if (clkdiv !== (j < 2)) $display("FAIL chg_old_clk j=%0d got %b exp %b", j, clkdiv, j < 2); else n_pass++;
         n_total++; if (cur_ratio !== 8'd4) $display("FAIL chg_old_ratio j=%0d got %0d exp 4", j, cur_ratio); else n_pass++;
      end
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         n_total++; if (clkdiv !== ((k % 7) < 3)) $display("FAIL r7_clk k=%0d got %b exp %b", k, clkdiv, (k % 7) < 3); else n_pass++;
         n_total++; if (tick !== ((k % 7) == 0)) $display("FAIL r7_tick k=%0d got %b exp %b", k, tick, (k % 7) == 0); else n_pass++;
         n_total++; if (req_ready !== 1'b1) $display("FAIL r7_ready k=%0d got %b exp 1", k, req_ready); else n_pass++;
         n_total++; if (cur_ratio !== 8'd7) $display("FAIL r7_ratio k=%0d got %0d exp 7", k, cur_ratio); else n_pass++;
      end
   endtask

   // Ratio 1 offered on the wrap edge: err pulses once, nothing else moves.
   task automatic test_illegal();
      req_valid = 1'b1; req_ratio = 8'd1;
      @(negedge clk);
      req_valid = 1'b0;
      n_total++; if (err !== 1'b1) $display("FAIL ill_err got %b exp 1", err); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL ill_ready got %b exp 1", req_ready); else n_pass++;
      n_total++; if (tick !== 1'b1) $display("FAIL ill_tick got %b exp 1", tick); else n_pass++;
      for (int k = 1; k < 14; k++) begin
         @(negedge clk);
         n_total++; if (err !== 1'b0) $display("FAIL ill_err_clr k=%0d got %b exp 0", k, err); else n_pass++;
         n_total++; if (clkdiv !== ((k % 7) < 3)) $display("FAIL ill_clk k=%0d got %b exp %b", k, clkdiv, (k % 7) < 3); else n_pass++;
         n_total++; if (cur_ratio !== 8'd7) $display("FAIL ill_ratio k=%0d got %0d exp 7", k, cur_ratio); else n_pass++;
      end
   endtask

   // en low on the last count stops at once; R=6 dropped at cnt=1 drains the full period;
   // then en returns at cnt=3 of a draining period and the waveform carries on untouched.
   task automatic test_drain();
      en = 1'b0;
      @(negedge clk);
      n_total++; if (running !== 1'b0) $display("FAIL stop_wrap_running got %b exp 0", running); else n_pass++;
      n_total++; if (clkdiv !== 1'b0) $display("FAIL stop_wrap_clk got %b exp 0", clkdiv); else n_pass++;
      req_valid = 1'b1; req_ratio = 8'd6;
      @(negedge clk);
      req_valid = 1'b0;
      n_total++; if (cur_ratio !== 8'd6) $display("FAIL idle_load got %0d exp 6", cur_ratio); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", req_ready); else n_pass++;
      en = 1'b1;
      @(negedge clk);
      n_total++; if (tick !== 1'b1) $display("FAIL dr_tick got %b exp 1", tick); else n_pass++;
      @(negedge clk);
      en = 1'b0;
      for (int c = 2; c < 6; c++) begin
         @(negedge clk);
         n_total++; if (running !== 1'b1) $display("FAIL dr_running cnt=%0d got %b exp 1", c, running); else n_pass++;
         n_total++; if (clkdiv !== (c < 3)) $display("FAIL dr_clk cnt=%0d got %b exp %b", c, clkdiv, c < 3); else n_pass++;
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_total++; if (running !== 1'b0) $display("FAIL dr_idle_running c=%0d got %b exp 0", c, running); else n_pass++;
         n_total++; if (clkdiv !== 1'b0) $display("FAIL dr_idle_clk c=%0d got %b exp 0", c, clkdiv); else n_pass++;
      end
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      n_total++; if (clkdiv !== 1'b1) $display("FAIL rr_cnt2_clk got %b exp 1", clkdiv); else n_pass++;
      @(negedge clk);
      en = 1'b1;
      for (int c = 4; c < 8; c++) begin
         @(negedge clk);
         n_total++; if (running !== 1'b1) $display("FAIL rr_running cnt=%0d got %b exp 1", c % 6, running); else n_pass++;
         n_total++; if (clkdiv !== ((c % 6) < 3)) $display("FAIL rr_clk cnt=%0d got %b exp %b", c % 6, clkdiv, (c % 6) < 3); else n_pass++;
         n_total++; if (tick !== ((c % 6) == 0)) $display("FAIL rr_tick cnt=%0d got %b exp %b", c % 6, tick, (c % 6) == 0); else n_pass++;
      end
   endtask

   // Reset at cnt=1 with en and a request also present: reset wins.
   task automatic test_reset_mid();
      rst = 1'b1; req_valid = 1'b1; req_ratio = 8'd9;
      @(negedge clk);
      n_total++; if (clkdiv !== 1'b0) $display("FAIL rm_clk got %b exp 0", clkdiv); else n_pass++;
      n_total++; if (running !== 1'b0) $display("FAIL rm_running got %b exp 0", running); else n_pass++;
      n_total++; if (cur_ratio !== 8'd4) $display("FAIL rm_ratio got %0d exp 4", cur_ratio); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL rm_tick got %b exp 0", tick); else n_pass++;
      n_total++; if (req_ready !== 1'b1) $display("FAIL rm_ready got %b exp 1", req_ready); else n_pass++;
      rst = 1'b0; en = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      n_total++; if (cur_ratio !== 8'd4) $display("FAIL rm_ratio_after got %0d exp 4", cur_ratio); else n_pass++;
      n_total++; if (clkdiv !== 1'b0) $display("FAIL rm_clk_after got %b exp 0", clkdiv); else n_pass++;
   endtask

   // R=2: request 3 accepted on the wrap edge runs one more R=2 period before applying.
   task automatic test_wrap_r2();
      req_valid = 1'b1; req_ratio = 8'd2;
      @(negedge clk);
      req_valid = 1'b0; en = 1'b1;
      @(negedge clk);
      n_total++; if (cur_ratio !== 8'd2) $display("FAIL w2_load got %0d exp 2", cur_ratio); else n_pass++;
      @(negedge clk);
      n_total++; if (clkdiv !== 1'b0) $display("FAIL w2_cnt1_clk got %b exp 0", clkdiv); else n_pass++;
      req_valid = 1'b1; req_ratio = 8'd3;
      @(negedge clk);
      req_valid = 1'b0;
      n_total++; if (req_ready !== 1'b0) $display("FAIL w2_ready0 got %b exp 0", req_ready); else n_pass++;
      n_total++; if (cur_ratio !== 8'd2) $display("FAIL w2_ratio0 got %0d exp 2", cur_ratio); else n_pass++;
      n_total++; if (tick !== 1'b1 || clkdiv !== 1'b1) $display("FAIL w2_p0 got tick=%b clk=%b exp 1 1", tick, clkdiv); else n_pass++;
      @(negedge clk);
      n_total++; if (req_ready !== 1'b0 || cur_ratio !== 8'd2 || clkdiv !== 1'b0) $display("FAIL w2_p1 got rdy=%b ratio=%0d clk=%b exp 0 2 0", req_ready, cur_ratio, clkdiv); else n_pass++;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_total++; if (cur_ratio !== 8'd3 || req_ready !== 1'b1) $display("FAIL w3_state k=%0d got ratio=%0d rdy=%b exp 3 1", k, cur_ratio, req_ready); else n_pass++;
         n_total++; if (clkdiv !== ((k % 3) == 0) || tick !== ((k % 3) == 0)) $display("FAIL w3_wave k=%0d got clk=%b tick=%b exp %b", k, clkdiv, tick, (k % 3) == 0); else n_pass++;
      end
   endtask

   // R=255: request 2 accepted on the wrap edge out of cnt=254 applies a full period later.
   task automatic test_wrap_r255();
      rst = 1'b1; en = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b1; req_ratio = 8'd255;
      @(negedge clk);
      req_valid = 1'b0; en = 1'b1;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         n_total++; if (clkdiv !== (i < 127)) $display("FAIL w255a_clk cnt=%0d got %b exp %b", i, clkdiv, i < 127); else n_pass++;
         if (i == 254) begin
            req_valid = 1'b1; req_ratio = 8'd2;
         end
      end
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         n_total++; if (req_ready !== 1'b0 || cur_ratio !== 8'd255) $display("FAIL w255b_state cnt=%0d got rdy=%b ratio=%0d exp 0 255", i, req_ready, cur_ratio); else n_pass++;
         n_total++; if (clkdiv !== (i < 127) || tick !== (i == 0)) $display("FAIL w255b_wave cnt=%0d got clk=%b tick=%b", i, clkdiv, tick); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (cur_ratio !== 8'd2 || req_ready !== 1'b1) $display("FAIL w255_apply got ratio=%0d rdy=%b exp 2 1", cur_ratio, req_ready); else n_pass++;
      n_total++; if (tick !== 1'b1 || clkdiv !== 1'b1) $display("FAIL w255_r2_p0 got tick=%b clk=%b exp 1 1", tick, clkdiv); else n_pass++;
      @(negedge clk);
      n_total++; if (tick !== 1'b0 || clkdiv !== 1'b0) $display("FAIL w255_r2_p1 got tick=%b clk=%b exp 0 0", tick, clkdiv); else n_pass++;
      en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ratio4();
      test_ratio_change();
      test_illegal();
      test_drain();
      test_reset_mid();
      test_wrap_r2();
      test_wrap_r255();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
